// File: rtl/nerv_umem_if.sv
// Memory-side request/response bus of the unified-memory arbiter.
// The arbiter is the master; the SRAM or bus bridge is the slave.
interface nerv_umem_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/nerv_umem_arbiter.sv
// Shares one variable-latency memory between the core's fetch and data ports, one step at a time.
// Optional one-entry fetch buffer enabled by defining NERV_ARB_FETCH_BUF_EN.
module nerv_umem_arbiter #(
    parameter int WAIT_MAX  = 255,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 resetn,
    output logic                 stall,
    input  logic [31:0]          imem_addr,
    output logic [31:0]          imem_data,
    input  logic                 dmem_valid,
    input  logic [31:0]          dmem_addr,
    input  logic [3:0]           dmem_wstrb,
    input  logic [31:0]          dmem_wdata,
    output logic [31:0]          dmem_rdata,
    nerv_umem_if.master          mem,
    output logic                 bus_err,
    output logic [CNT_WIDTH-1:0] retired
);
    localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_DATA, S_COMMIT} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            fetch_addr_q, fetch_addr_d;
    logic [31:0]            imem_data_q, imem_data_d;
    logic [31:0]            dmem_rdata_q, dmem_rdata_d;
    logic [31:0]            daddr_q, daddr_d;
    logic [3:0]             dwstrb_q, dwstrb_d;
    logic [31:0]            dwdata_q, dwdata_d;
    logic                   stall_q, stall_d;
    logic                   mem_valid_q, mem_valid_d;
    logic                   bus_err_q, bus_err_d;
    logic [CNT_WIDTH-1:0]   retired_q, retired_d;
    logic [CW-1:0]          wait_cnt_q, wait_cnt_d;
    logic                   req_done;
    logic                   next_hit;
`ifdef NERV_ARB_FETCH_BUF_EN
    logic                   buf_valid_q, buf_valid_d;
    logic [29:0]            buf_addr_q, buf_addr_d;
    logic [31:0]            buf_data_q, buf_data_d;
    logic                   buf_hit;
`endif

    assign req_done = mem_valid_q && mem.mem_ready;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        imem_data_d  = imem_data_q;
        dmem_rdata_d = dmem_rdata_q;
        daddr_d      = daddr_q;
        dwstrb_d     = dwstrb_q;
        dwdata_d     = dwdata_q;
        retired_d    = retired_q;
        wait_cnt_d   = wait_cnt_q;
`ifdef NERV_ARB_FETCH_BUF_EN
        buf_valid_d  = buf_valid_q;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        buf_hit      = buf_valid_q && (buf_addr_q == fetch_addr_q[31:2]);
`endif

        case (state_q)
            S_IDLE: begin
                fetch_addr_d = imem_addr;
                state_d      = S_FETCH;
            end
            S_FETCH: begin
`ifdef NERV_ARB_FETCH_BUF_EN
                if (buf_hit) begin
                    imem_data_d = buf_data_q;
                    state_d     = S_DECODE;
                end else
`endif
                if (req_done) begin
                    imem_data_d = mem.mem_rdata;
                    state_d     = S_DECODE;
`ifdef NERV_ARB_FETCH_BUF_EN
                    buf_valid_d = 1'b1;
                    buf_addr_d  = fetch_addr_q[31:2];
                    buf_data_d  = mem.mem_rdata;
`endif
                end
            end
            S_DECODE: begin
                if (dmem_valid) begin
                    daddr_d  = dmem_addr;
                    dwstrb_d = dmem_wstrb;
                    dwdata_d = dmem_wdata;
                    state_d  = S_DATA;
                end else begin
                    state_d  = S_COMMIT;
                end
            end
            S_DATA: begin
                if (req_done) begin
                    if (dwstrb_q == 4'b0000)
                        dmem_rdata_d = mem.mem_rdata;
`ifdef NERV_ARB_FETCH_BUF_EN
                    // A store into the buffered word makes the cached instruction stale.
                    else if (buf_valid_q && buf_addr_q == daddr_q[31:2])
                        buf_valid_d = 1'b0;
`endif
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                retired_d    = retired_q + CNT_WIDTH'(1);
                fetch_addr_d = imem_addr;
                state_d      = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef NERV_ARB_FETCH_BUF_EN
        next_hit = buf_valid_d && (buf_addr_d == fetch_addr_d[31:2]);
`else
        next_hit = 1'b0;
`endif

        // Outputs are registered from the next state so they are glitch-free flops.
        stall_d     = (state_d != S_COMMIT);
        mem_valid_d = (state_d == S_DATA) || (state_d == S_FETCH && !next_hit);

        if (state_d != state_q && (state_d == S_FETCH || state_d == S_DATA))
            wait_cnt_d = '0;
        else if (WAIT_MAX != 0 && mem_valid_q && !mem.mem_ready && wait_cnt_q != CW'(WAIT_MAX))
            wait_cnt_d = wait_cnt_q + CW'(1);

        bus_err_d = bus_err_q ||
                    ((WAIT_MAX != 0) && mem_valid_q && (wait_cnt_q == CW'(WAIT_MAX)));
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            fetch_addr_q <= '0;
            imem_data_q  <= '0;
            dmem_rdata_q <= '0;
            daddr_q      <= '0;
            dwstrb_q     <= '0;
            dwdata_q     <= '0;
            stall_q      <= 1'b1;
            mem_valid_q  <= 1'b0;
            bus_err_q    <= 1'b0;
            retired_q    <= '0;
            wait_cnt_q   <= '0;
`ifdef NERV_ARB_FETCH_BUF_EN
            buf_valid_q  <= 1'b0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            imem_data_q  <= imem_data_d;
            dmem_rdata_q <= dmem_rdata_d;
            daddr_q      <= daddr_d;
            dwstrb_q     <= dwstrb_d;
            dwdata_q     <= dwdata_d;
            stall_q      <= stall_d;
            mem_valid_q  <= mem_valid_d;
            bus_err_q    <= bus_err_d;
            retired_q    <= retired_d;
            wait_cnt_q   <= wait_cnt_d;
`ifdef NERV_ARB_FETCH_BUF_EN
            buf_valid_q  <= buf_valid_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
`endif
        end
    end

    // Request fields are pure functions of held state, so they stay put while a request waits.
    assign mem.mem_valid = mem_valid_q;
    assign mem.mem_addr  = ((state_q == S_DATA) ? daddr_q : fetch_addr_q) & 32'hFFFF_FFFC;
    assign mem.mem_wstrb = (state_q == S_DATA) ? dwstrb_q : 4'b0000;
    assign mem.mem_wdata = dwdata_q;

    assign stall      = stall_q;
    assign imem_data  = imem_data_q;
    assign dmem_rdata = dmem_rdata_q;
    assign bus_err    = bus_err_q;
    assign retired    = retired_q;
endmodule
